// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder sequencer.
package serial_add_pkg;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam int unsigned SERIAL_ADD_W = 8;

endpackage

// File: rtl/fulladd.sv
// Existing 1-bit full adder cell, port order (sum, c_out, a, b, c_in).
module fulladd (
  output logic sum_o,
  output logic c_out_o,
  input  logic a_i,
  input  logic b_i,
  input  logic c_in_i
);

  assign sum_o   = a_i ^ b_i ^ c_in_i;
  assign c_out_o = (a_i & b_i) | (c_in_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial W-bit adder: drives one fulladd per clock, LSB first, with valid/ready handshakes.
// Optional subtract mode (sub_i port) is enabled by defining SERIAL_ADD_SUB_EN.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned W = SERIAL_ADD_W
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         start_valid_i,
  output logic         start_ready_o,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         c_in_i,
`ifdef SERIAL_ADD_SUB_EN
  input  logic         sub_i,
`endif
  output logic         res_valid_o,
  input  logic         res_ready_i,
  output logic [W-1:0] sum_o,
  output logic         c_out_o,
  output logic         busy_o
);

  localparam int unsigned CntW = (W > 1) ? $clog2(W) : 1;

  state_e        state_q, state_d;
  logic [W-1:0]  a_q, b_q, res_q;
  logic [W-1:0]  a_shift, b_shift, res_shift;
  logic          carry_q;
  logic [CntW-1:0] cnt_q;
  logic          fa_sum, fa_cout;
  logic          start_hs, res_hs, last_bit;
  logic [W-1:0]  b_load;
  logic          c_load;

`ifdef SERIAL_ADD_SUB_EN
  // A - B computed as A + ~B + 1; c_out=1 means no borrow.
  assign b_load = sub_i ? ~b_i : b_i;
  assign c_load = sub_i ? 1'b1 : c_in_i;
`else
  assign b_load = b_i;
  assign c_load = c_in_i;
`endif

  assign start_hs = start_valid_i && (state_q == StIdle);
  assign res_hs   = res_ready_i && (state_q == StDone);
  assign last_bit = (cnt_q == CntW'(W - 1));

  fulladd u_fulladd (
    .sum_o  (fa_sum),
    .c_out_o(fa_cout),
    .a_i    (a_q[0]),
    .b_i    (b_q[0]),
    .c_in_i (carry_q)
  );

  // Written with shifts so W=1 needs no special-case slicing.
  always_comb begin
    a_shift        = a_q >> 1;
    b_shift        = b_q >> 1;
    res_shift      = res_q >> 1;
    res_shift[W-1] = fa_sum;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_hs) state_d = StRun;
      StRun:   if (last_bit) state_d = StDone;
      StDone:  if (res_hs)   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    start_ready_o = 1'b0;
    res_valid_o   = 1'b0;
    busy_o        = 1'b0;
    unique case (state_q)
      StIdle:  start_ready_o = 1'b1;
      StRun:   busy_o        = 1'b1;
      StDone:  begin
        res_valid_o = 1'b1;
        busy_o      = 1'b1;
      end
      default: start_ready_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else if (start_hs) begin
      a_q     <= a_i;
      b_q     <= b_load;
      carry_q <= c_load;
      cnt_q   <= '0;
    end else if (state_q == StRun) begin
      a_q     <= a_shift;
      b_q     <= b_shift;
      res_q   <= res_shift;
      carry_q <= fa_cout;
      cnt_q   <= cnt_q + CntW'(1);
    end
  end

  assign sum_o   = res_q;
  assign c_out_o = carry_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl (W=8 and W=1 instances) with a result scoreboard.
module tb_serial_add_ctrl;

  localparam int unsigned W = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       sv8, sr8, rv8, rr8, c8, co8, busy8;
  logic [7:0] a8, b8, s8;
`ifdef SERIAL_ADD_SUB_EN
  logic       sub8;
`endif
  logic       sv1, sr1, rv1, rr1, c1, co1, busy1;
  logic [0:0] a1, b1, s1;

  int         checks = 0;
  int         errors = 0;
  logic [8:0] q8[$];
  logic [1:0] q1[$];

  serial_add_ctrl #(.W(W)) u_dut8 (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_valid_i(sv8),
    .start_ready_o(sr8),
    .a_i          (a8),
    .b_i          (b8),
    .c_in_i       (c8),
`ifdef SERIAL_ADD_SUB_EN
    .sub_i        (sub8),
`endif
    .res_valid_o  (rv8),
    .res_ready_i  (rr8),
    .sum_o        (s8),
    .c_out_o      (co8),
    .busy_o       (busy8)
  );

  serial_add_ctrl #(.W(1)) u_dut1 (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_valid_i(sv1),
    .start_ready_o(sr1),
    .a_i          (a1),
    .b_i          (b1),
    .c_in_i       (c1),
`ifdef SERIAL_ADD_SUB_EN
    .sub_i        (1'b0),
`endif
    .res_valid_o  (rv1),
    .res_ready_i  (rr1),
    .sum_o        (s1),
    .c_out_o      (co1),
    .busy_o       (busy1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One W=8 operation; exp is {c_out, sum}. Result is held unaccepted for 'hold' cycles.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic c, input logic s,
                        input int hold, input logic [8:0] exp);
    int n;
    @(negedge clk);
    a8 = a; b8 = b; c8 = c; sv8 = 1'b1;
`ifdef SERIAL_ADD_SUB_EN
    sub8 = s;
`endif
    chk("start_ready_idle", sr8, 1);
    @(posedge clk);
    q8.push_back(exp);
    @(negedge clk);
    sv8 = 1'b0; a8 = ~a; b8 = ~b; c8 = ~c;
`ifdef SERIAL_ADD_SUB_EN
    sub8 = ~s;
`endif
    n = 1;
    chk("busy_run", busy8, 1);
    chk("start_ready_run", sr8, 0);
    while (!rv8 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, W + 1);
    chk("result", {co8, s8}, q8[0]);
    repeat (hold) begin
      @(negedge clk);
      chk("hold_valid", rv8, 1);
      chk("hold_result", {co8, s8}, q8[0]);
    end
    rr8 = 1'b1;
    @(posedge clk);
    void'(q8.pop_front());
    @(negedge clk);
    rr8 = 1'b0;
    chk("res_valid_drop", rv8, 0);
    chk("start_ready_back", sr8, 1);
    chk("busy_idle", busy8, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int n;
    sv8 = 0; rr8 = 0; a8 = 0; b8 = 0; c8 = 0;
`ifdef SERIAL_ADD_SUB_EN
    sub8 = 0;
`endif
    sv1 = 0; rr1 = 0; a1 = 0; b1 = 0; c1 = 0;
    repeat (2) @(negedge clk);
    chk("rst_start_ready", sr8, 1);
    chk("rst_res_valid", rv8, 0);
    chk("rst_sum", s8, 0);
    chk("rst_c_out", co8, 0);
    chk("rst_busy", busy8, 0);
    rst_n = 1'b1;

    run_op(8'h0F, 8'h01, 1'b0, 1'b0, 0, 9'h010);
    run_op(8'hFF, 8'h01, 1'b1, 1'b0, 5, 9'h101);
    run_op(8'hAA, 8'h55, 1'b1, 1'b0, 1, 9'h100);

    // Back-to-back with start_valid and res_ready held high.
    @(negedge clk);
    a8 = 8'd3; b8 = 8'd4; c8 = 1'b0; sv8 = 1'b1; rr8 = 1'b1;
    @(posedge clk);
    q8.push_back(9'h007);
    @(negedge clk);
    a8 = 8'd5; b8 = 8'd6;
    for (int k = 1; k <= int'(W) + 1; k++) begin
      if (k > 1) @(negedge clk);
      chk("b2b_start_ready_low", sr8, 0);
      chk("b2b_res_valid", rv8, (k == int'(W) + 1));
    end
    chk("b2b_result1", {co8, s8}, q8[0]);
    @(posedge clk);
    void'(q8.pop_front());
    @(negedge clk);
    chk("b2b_start_ready_again", sr8, 1);
    @(posedge clk);
    q8.push_back(9'h00B);
    @(negedge clk);
    sv8 = 1'b0;
    n = 1;
    while (!rv8 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_latency2", n, W + 1);
    chk("b2b_result2", {co8, s8}, q8[0]);
    @(posedge clk);
    void'(q8.pop_front());
    @(negedge clk);
    rr8 = 1'b0;
    chk("b2b_idle", sr8, 1);

    // Reset in the middle of RUN drops the operation.
    a8 = 8'h33; b8 = 8'h44; sv8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sv8 = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", busy8, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_start_ready", sr8, 1);
    chk("mid_rst_res_valid", rv8, 0);
    chk("mid_rst_sum", s8, 0);
    chk("mid_rst_c_out", co8, 0);
    chk("mid_rst_busy", busy8, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      chk("post_rst_no_valid", rv8, 0);
    end
    run_op(8'h01, 8'h01, 1'b0, 1'b0, 0, 9'h002);

`ifdef SERIAL_ADD_SUB_EN
    run_op(8'h05, 8'h07, 1'b0, 1'b1, 0, 9'h0FE);
    run_op(8'h07, 8'h05, 1'b0, 1'b1, 0, 9'h102);
    run_op(8'h07, 8'h05, 1'b0, 1'b0, 0, 9'h00C);
`endif

    // W=1 instance: exactly one RUN cycle.
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b1; c1 = 1'b1; sv1 = 1'b1;
    chk("w1_start_ready", sr1, 1);
    @(posedge clk);
    q1.push_back(2'b11);
    @(negedge clk);
    sv1 = 1'b0;
    n = 1;
    while (!rv1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("w1_latency", n, 2);
    chk("w1_result", {co1, s1}, q1[0]);
    rr1 = 1'b1;
    @(posedge clk);
    void'(q1.pop_front());
    @(negedge clk);
    rr1 = 1'b0;
    chk("w1_res_valid_drop", rv1, 0);
    chk("w1_busy_idle", busy1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial adder sequencer built around the team's existing 1-bit `fulladd` cell. It accepts two W-bit operands plus a carry-in over a valid/ready handshake. It then drives the single full adder once per clock, LSB first, while a carry register closes the loop. It returns the W-bit sum and final carry over a second valid/ready handshake. It is the controller that turns the 1-bit cell into a multi-bit arithmetic resource with one adder's worth of area.

## Interface
- W, 8, operand/result width in bits (legal: 1..64)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start_valid  in  1  requester presents an operation
- start_ready  out  1  controller can accept; high only in IDLE
- a  in  W  operand A, sampled at start handshake
- b  in  W  operand B, sampled at start handshake
- c_in  in  1  carry-in, sampled at start handshake
- sub  in  1  subtract select; exists only when SERIAL_ADD_SUB_EN is defined
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- sum  out  W  result bits
- c_out  out  1  final carry (carry out of bit W-1)
- busy  out  1  high in RUN or DONE

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE
  - start_ready=1.
  - On start_valid && start_ready: latch a and b into shift registers, load the carry register with c_in, clear bit counter, go to RUN.
- RUN
  - Each cycle, the fulladd inputs are the LSB of the A shift register, the LSB of the B shift register, and the carry register.
  - The fulladd sum bit shifts into the MSB of the result shift register (right shift); A and B shift right.
  - The carry register takes the fulladd c_out.
  - The counter increments; after the cycle with counter==W-1, go to DONE.
- DONE
  - res_valid=1; sum and c_out are held stable.
  - On res_valid && res_ready: go to IDLE.
- Operands are captured only at the handshake. Changes on a, b, c_in, or sub during RUN or DONE are ignored. start_valid outside IDLE is ignored and is not queued.
- Arithmetic is modulo 2^W. c_out is the true carry out of bit W-1. No overflow flag.
- Counter width is $clog2(W) bits, minimum 1. W=1 performs exactly one RUN cycle.
- Reset, including asserting rst_n mid-RUN or mid-DONE:
  - state=IDLE, result and operand registers=0, carry register=0.
  - Any in-flight operation is dropped with no res_valid.
- Reset output values: start_ready=1, res_valid=0, sum=0, c_out=0, busy=0.

## Timing
- Start handshake in cycle 0. RUN occupies cycles 1..W. res_valid rises at the start of cycle W+1.
- Handshake-to-result latency is W+1 clocks.
- With res_ready held high, the result handshake completes in cycle W+1 and start_ready=1 in cycle W+2.
- Throughput: one operation per W+2 cycles.
- There is no same-cycle result-accept and new-start; start_ready is a pure decode of state==IDLE.
- res_valid stays high with stable data for any number of cycles until res_ready.
- busy is a registered-state decode with no combinational path from inputs.

## Configuration
- Controlled by the macro SERIAL_ADD_SUB_EN.
- Defined:
  - The sub port exists.
  - When sub=1 at the start handshake, B is latched inverted and the carry register is loaded with 1; c_in is ignored. The result is A−B mod 2^W, with c_out=1 meaning no borrow.
  - When sub=0, the operation is identical to an add.
- Undefined:
  - The sub port is absent; the block is add-only with A+B+c_in.
  - No inverter logic is present.

## Structure
- Shared package serial_add_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the default width constant SERIAL_ADD_W=8.
- Exactly one sub-module: the existing 1-bit cell `fulladd`, instantiated once with port order (sum, c_out, a, b, c_in).
- All sequencing, shift registers and handshakes live in serial_add_ctrl. No other hierarchy.

## Test plan
- W=8, a=8'h0F, b=8'h01, c_in=0 -> res_valid at cycle 9; sum=8'h10, c_out=0.
- W=8, a=8'hFF, b=8'h01, c_in=1 -> sum=8'h01, c_out=1. Then hold res_ready=0 for 5 cycles -> sum, c_out and res_valid stay stable throughout.
- Back-to-back with start_valid and res_ready held high, a=3, b=4 then a=5, b=6 -> sums 7 and 11. Second start accepted exactly W+2 cycles after the first. start_valid during RUN is not accepted.
- Drop rst_n at cycle 4 of RUN -> outputs go immediately to reset values; no res_valid. The next op a=1, b=1 returns sum=2.
- W=1: a=1, b=1, c_in=1 -> sum=1, c_out=1, res_valid at cycle 2.
- With SERIAL_ADD_SUB_EN defined, W=8:
  - sub=1, a=8'h05, b=8'h07 -> sum=8'hFE, c_out=0.
  - sub=1, a=8'h07, b=8'h05 -> sum=8'h02, c_out=1.
